// File: rtl/benes_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : benes_cfg_sequencer
// Description : Pairs each accepted input vector with the next entry of a
//               small switch-setting table and issues the aligned pair to
//               the Benes distribution network. Tracks the network latency
//               so it can flag valid results and signal run completion.
// Revision    : 1.0 - initial release
// ============================================================================
module benes_cfg_sequencer #(
    parameter int DATA_TYPE = 16,
    parameter int NUM_PES   = 8,
    parameter int LEVELS    = 7,
    parameter int MUX_W     = 2*(LEVELS-2)*NUM_PES+NUM_PES,
    parameter int DEPTH     = 4,
    parameter int AW        = $clog2(DEPTH),
    parameter int BENES_LAT = 1,
    parameter int CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_cfg_wr_en,
    input  logic [AW-1:0]                i_cfg_wr_addr,
    input  logic [MUX_W-1:0]             i_cfg_wr_data,
    input  logic                         i_start,
    input  logic [AW-1:0]                i_base_addr,
    input  logic [CNT_W-1:0]             i_count,
    input  logic                         i_data_valid,
    input  logic [NUM_PES*DATA_TYPE-1:0] i_data_bus,
    output logic                         o_data_ready,
    output logic [MUX_W-1:0]             o_mux_bus,
    output logic [NUM_PES*DATA_TYPE-1:0] o_data_bus,
    output logic                         o_issue_valid,
    output logic                         o_dist_valid,
    output logic                         o_busy,
    output logic                         o_done
);

    localparam int DW = NUM_PES*DATA_TYPE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [MUX_W-1:0]   mux_q, mux_d;
    logic [DW-1:0]      data_q, data_d;
    logic               issue_q, issue_d;
    logic               done_q, done_d;
    logic [MUX_W-1:0]   table_q [DEPTH];

    logic               w_accept;
    logic               w_pipe_pending;
    logic [BENES_LAT:0] w_vline;

    // Table write port; a read of the same address this cycle sees the old word.
    always_ff @(posedge clk) begin
        if (i_cfg_wr_en) begin
            table_q[i_cfg_wr_addr] <= i_cfg_wr_data;
        end
    end

    assign o_data_ready = (state_q == ST_RUN);
    assign w_accept     = i_data_valid && o_data_ready;

    // Valid delay line modelling the network pipeline. w_vline[0] is the
    // issue stage, w_vline[BENES_LAT] is the network output stage.
    generate
        if (BENES_LAT == 0) begin : g_lat0
            assign w_vline        = issue_q;
            assign w_pipe_pending = 1'b0;
        end else begin : g_latn
            logic [BENES_LAT-1:0] dly_q;
            // Shift issue flags toward the network output.
            always_ff @(posedge clk) begin
                if (rst) begin
                    dly_q <= '0;
                end else begin
                    dly_q <= (dly_q << 1) | BENES_LAT'(issue_q);
                end
            end
            assign w_vline        = {dly_q, issue_q};
            // Anything still upstream of the output stage keeps the drain open.
            assign w_pipe_pending = |w_vline[BENES_LAT-1:0];
        end
    endgenerate

    assign o_dist_valid  = w_vline[BENES_LAT];
    assign o_mux_bus     = mux_q;
    assign o_data_bus    = data_q;
    assign o_issue_valid = issue_q;
    assign o_busy        = (state_q != ST_IDLE);
    assign o_done        = done_q;

    // Next-state and datapath-load decisions for the run sequencer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        mux_d   = mux_q;
        data_d  = data_q;
        issue_d = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_count != '0) begin
                        state_d = ST_RUN;
                        ptr_d   = i_base_addr;
                        rem_d   = i_count;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    mux_d   = table_q[ptr_q];
                    data_d  = i_data_bus;
                    issue_d = 1'b1;
                    ptr_d   = ptr_q + AW'(1);
                    rem_d   = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Leave once the final result is at the network output.
                if (!w_pipe_pending) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any run in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            mux_q   <= '0;
            data_q  <= '0;
            issue_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            mux_q   <= mux_d;
            data_q  <= data_d;
            issue_q <= issue_d;
            done_q  <= done_d;
        end
    end

endmodule
`default_nettype wire
